// File: rtl/carry_norm_16_if.sv
// carry_norm_16_if: column-sum input stream and normalized-word output stream of carry_norm_16
interface carry_norm_16_if #(
  parameter int W  = 16,
  parameter int SW = 48
);
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] in_sum;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_word;
  logic          out_last;
  modport master (output in_valid, in_sum, in_last, out_ready,
                  input  in_ready, out_valid, out_word, out_last);
  modport slave  (input  in_valid, in_sum, in_last, out_ready,
                  output in_ready, out_valid, out_word, out_last);
endinterface

// File: rtl/carry_norm_16.sv
// carry_norm_16: carry-propagates redundant column sums into W-bit words plus flush words; optional CARRY_NORM_STATUS_EN adds word_cnt/ovf
module carry_norm_16 #(
  parameter int W           = 16,
  parameter int SW          = 48,
  parameter int FLUSH_WORDS = 3
) (
  input  logic clk,
  input  logic rst,
  carry_norm_16_if.slave s
`ifdef CARRY_NORM_STATUS_EN
  ,
  output logic [7:0] word_cnt,
  output logic       ovf
`endif
);
  localparam int CW = SW - W + 1;
  localparam int NW = $clog2(FLUSH_WORDS + 1);
  typedef enum logic {RUN, FLUSH} state_t;
  state_t        state_q, state_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] c_q, c_d, c_sh;
  logic [W-1:0]  word_q, word_d;
  logic          valid_q, valid_d, last_q, last_d;
  logic          out_free, accept, fl_load, fl_end;
  logic [SW:0]   t;
  always_comb begin
    out_free = !valid_q || s.out_ready;
    t        = {1'b0, s.in_sum} + (SW+1)'(c_q);
    c_sh     = c_q >> W;
    accept   = s.in_valid && s.in_ready;
    fl_load  = state_q == FLUSH && out_free;
    fl_end   = fl_load && cnt_q == '0;
    word_d   = accept ? t[W-1:0] : fl_load ? c_q[W-1:0] : word_q;
    valid_d  = accept || fl_load || (valid_q && !s.out_ready);
    last_d   = accept ? 1'b0 : fl_load ? fl_end : last_q;
    c_d      = accept ? CW'(t >> W) : fl_end ? '0 : fl_load ? c_sh : c_q;
    state_d  = (accept && s.in_last) ? FLUSH : fl_end ? RUN : state_q;
    cnt_d    = (accept && s.in_last) ? NW'(FLUSH_WORDS - 1) :
               (fl_load && !fl_end) ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      c_q     <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end
  assign s.in_ready  = state_q == RUN && out_free && !rst;
  assign s.out_valid = valid_q;
  assign s.out_word  = word_q;
  assign s.out_last  = last_q;
`ifdef CARRY_NORM_STATUS_EN
  logic [7:0] word_cnt_q, word_cnt_d;
  logic       ovf_q, ovf_d;
  always_comb begin
    word_cnt_d = (valid_q && s.out_ready) ? (last_q ? 8'd0 : word_cnt_q + 8'd1) : word_cnt_q;
    // carry left over after the final flush word would be lost
    ovf_d      = ovf_q || (fl_end && c_sh != '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      word_cnt_q <= word_cnt_d;
      ovf_q      <= ovf_d;
    end
  end
  assign word_cnt = word_cnt_q;
  assign ovf      = ovf_q;
`endif
endmodule

// File: tb/tb_carry_norm_16.sv
// tb_carry_norm_16: scoreboard bench for carry_norm_16; status ports checked when CARRY_NORM_STATUS_EN is defined
module tb_carry_norm_16;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  carry_norm_16_if m();
`ifdef CARRY_NORM_STATUS_EN
  logic [7:0] word_cnt;
  logic       ovf;
  carry_norm_16 dut (.clk(clk), .rst(rst), .s(m), .word_cnt(word_cnt), .ovf(ovf));
`else
  carry_norm_16 dut (.clk(clk), .rst(rst), .s(m));
`endif
  int          checks = 0;
  int          errors = 0;
  logic [16:0] q[$];
  logic [16:0] obs[$];
  logic [47:0] cs[8];
  logic        cl[8];
  logic [32:0] mc;
  bit          in_flush;
  int          exp_wc;

  task automatic run(input int n, input int mode);
    int          i = 0;
    int          cyc = 0;
    logic [48:0] t;
    logic [16:0] e;
    obs.delete();
    while ((i < n || q.size() > 0) && cyc < 300) begin
      @(negedge clk);
      cyc++;
      m.out_ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 3 == 1) : 1'($urandom_range(0, 1));
      m.in_valid  = i < n;
      m.in_sum    = i < n ? cs[i] : 48'd0;
      m.in_last   = i < n ? cl[i] : 1'b0;
      #1;
      if (m.out_valid && m.out_last) in_flush = 0;
      if (in_flush || (m.out_valid && !m.out_ready)) begin
        checks++;
        if (m.in_ready !== 1'b0) begin
          errors++;
          $display("FAIL in_ready_stall: got %b expected 0 (cycle %0d)", m.in_ready, cyc);
        end
      end
      if (m.out_valid && m.out_ready) begin
        checks++;
        obs.push_back({m.out_last, m.out_word});
        if (q.size() == 0) begin
          errors++;
          $display("FAIL extra_word: got %h with nothing expected", {m.out_last, m.out_word});
        end else begin
          e = q.pop_front();
          if ({m.out_last, m.out_word} !== e) begin
            errors++;
            $display("FAIL word: got last=%b word=%h expected last=%b word=%h", m.out_last, m.out_word, e[16], e[15:0]);
          end
        end
`ifdef CARRY_NORM_STATUS_EN
        checks++;
        if (word_cnt !== 8'(exp_wc)) begin
          errors++;
          $display("FAIL word_cnt: got %0d expected %0d", word_cnt, exp_wc);
        end
        exp_wc = m.out_last ? 0 : exp_wc + 1;
`endif
      end
      if (m.in_valid && m.in_ready) begin
        t = {1'b0, cs[i]} + 49'(mc);
        q.push_back({1'b0, t[15:0]});
        mc = 33'(t >> 16);
        if (cl[i]) begin
          for (int k = 0; k < 3; k++) begin
            q.push_back({k == 2, mc[15:0]});
            mc = mc >> 16;
          end
          mc = '0;
          in_flush = 1;
        end
        i++;
      end
    end
    checks++;
    if (cyc >= 300 || q.size() != 0) begin
      errors++;
      $display("FAIL timeout: got %0d words pending after %0d cycles expected 0", q.size(), cyc);
    end
    @(posedge clk);
    q.delete();
  endtask

  task automatic test_reset();
    rst = 1; m.in_valid = 0; m.in_sum = '0; m.in_last = 0; m.out_ready = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({m.out_valid, m.out_word, m.out_last, m.in_ready} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b word=%h last=%b in_ready=%b expected all 0", m.out_valid, m.out_word, m.out_last, m.in_ready);
    end
`ifdef CARRY_NORM_STATUS_EN
    checks++;
    if (word_cnt !== 8'd0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: got word_cnt=%0d ovf=%b expected 0 0", word_cnt, ovf);
    end
`endif
    @(negedge clk);
    rst = 0; mc = '0; exp_wc = 0; in_flush = 0;
    #1;
    checks++;
    if (m.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b expected 1", m.in_ready);
    end
  endtask

  task automatic test_basic(input int mode);
    logic [16:0] ex[5];
    ex = '{17'h0FFFF, 17'h00002, 17'h00000, 17'h00000, 17'h10000};
    cs[0] = 48'h0000_0001_FFFF; cl[0] = 0;
    cs[1] = 48'h0000_0000_0001; cl[1] = 1;
    run(2, mode);
    checks++;
    if (obs.size() != 5) begin
      errors++;
      $display("FAIL basic_count mode%0d: got %0d expected 5", mode, obs.size());
    end else
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (obs[k] !== ex[k]) begin
          errors++;
          $display("FAIL basic_word%0d mode%0d: got %h expected %h", k, mode, obs[k], ex[k]);
        end
      end
  endtask

  task automatic test_max();
    logic [16:0] ex[5];
    ex = '{17'h0FFFF, 17'h0FFFE, 17'h0FFFF, 17'h00000, 17'h10001};
    cs[0] = 48'hFFFF_FFFF_FFFF; cl[0] = 0;
    cs[1] = 48'hFFFF_FFFF_FFFF; cl[1] = 1;
    run(2, 0);
    checks++;
    if (obs.size() != 5) begin
      errors++;
      $display("FAIL max_count: got %0d expected 5", obs.size());
    end else
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (obs[k] !== ex[k]) begin
          errors++;
          $display("FAIL max_word%0d: got %h expected %h", k, obs[k], ex[k]);
        end
      end
    checks++;
    if (dut.c_q !== 33'd0) begin
      errors++;
      $display("FAIL max_carry_cleared: got %h expected 0", dut.c_q);
    end
`ifdef CARRY_NORM_STATUS_EN
    checks++;
    if (ovf !== 1'b0 || word_cnt !== 8'd0) begin
      errors++;
      $display("FAIL max_status: got ovf=%b word_cnt=%0d expected 0 0", ovf, word_cnt);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [16:0] ex[4];
    ex = '{17'h00005, 17'h00000, 17'h00000, 17'h10000};
    cs[0] = 48'h0000_0001_FFFF; cl[0] = 0;
    cs[1] = 48'h0000_0000_0001; cl[1] = 1;
    cs[2] = 48'h0000_0000_0005; cl[2] = 1;
    run(3, 0);
    checks++;
    if (obs.size() != 9) begin
      errors++;
      $display("FAIL b2b_count: got %0d expected 9", obs.size());
    end else
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (obs[k+5] !== ex[k]) begin
          errors++;
          $display("FAIL b2b_word%0d: got %h expected %h", k, obs[k+5], ex[k]);
        end
      end
  endtask

  task automatic test_reset_mid();
    logic [16:0] ex[4];
    ex = '{17'h00007, 17'h00000, 17'h00000, 17'h10000};
    @(negedge clk);
    m.out_ready = 1; m.in_valid = 1; m.in_sum = 48'h1FFFF; m.in_last = 0;
    @(negedge clk);
    m.in_sum = 48'h1; m.in_last = 1;
    @(negedge clk);
    m.in_valid = 0; m.in_last = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (m.out_valid !== 1'b1 || m.out_last !== 1'b0) begin
      errors++;
      $display("FAIL mid_flush_word: got valid=%b last=%b expected 1 0", m.out_valid, m.out_last);
    end
    rst = 1;
    @(negedge clk);
    rst = 0; mc = '0; exp_wc = 0; in_flush = 0;
    #1;
    checks++;
    if (m.out_valid !== 1'b0 || m.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: got out_valid=%b in_ready=%b expected 0 1", m.out_valid, m.in_ready);
    end
    cs[0] = 48'h7; cl[0] = 1;
    run(1, 0);
    checks++;
    if (obs.size() != 4) begin
      errors++;
      $display("FAIL mid_count: got %0d expected 4", obs.size());
    end else
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (obs[k] !== ex[k]) begin
          errors++;
          $display("FAIL mid_word%0d: got %h expected %h", k, obs[k], ex[k]);
        end
      end
  endtask

  task automatic test_random();
    logic [63:0] r;
    int          n;
    for (int op = 0; op < 6; op++) begin
      n = $urandom_range(1, 5);
      for (int j = 0; j < n; j++) begin
        r = {$urandom(), $urandom()};
        cs[j] = (op == 0) ? 48'hFFFF_FFFF_FFFF : r[47:0];
        cl[j] = j == n - 1;
      end
      run(n, 2);
    end
`ifdef CARRY_NORM_STATUS_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL random_ovf: got %b expected 0", ovf);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic(0);
    test_max();
    test_basic(1);
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
